divider_iterative: RTL
======================

// Module: divider_iterative
// PURPOSE
//  Multi-cycle integer divider; successor to the single-cycle 32-stage combinational divider.
//  Retires BITS_PER_CYCLE restoring-division steps per clock, trading latency for area/timing.
//  Adds signed mode (RISC-V DIV/DIVU/REM/REMU semantics), valid/ready handshakes and flush.
//  Sits in the execute stage as the long-latency DIV/REM functional unit.
// PARAMETERS
//  WIDTH           32  operand/result width in bits
//  BITS_PER_CYCLE  4   quotient bits retired per RUN cycle; must divide WIDTH (elaboration $error otherwise)
// PORTS
//  clk          in   1      clock, all state updates on rising edge
//  rst          in   1      reset, asynchronous, active-high
//  i_flush      in   1      synchronous abort: return to IDLE, discard op
//  i_in_valid   in   1      operands valid
//  o_in_ready   out  1      unit can accept (high only in IDLE)
//  i_dividend   in   WIDTH  dividend
//  i_divisor    in   WIDTH  divisor
//  i_signed     in   1      1 = two's-complement DIV/REM, 0 = unsigned
//  o_out_valid  out  1      result valid (high only in DONE)
//  i_out_ready  in   1      consumer takes result
//  o_quotient   out  WIDTH  quotient
//  o_remainder  out  WIDTH  remainder
// BEHAVIOUR
//  - Reset (async assert): state=IDLE, o_in_ready=1, o_out_valid=0, o_quotient=0, o_remainder=0.
//  - Let N = WIDTH/BITS_PER_CYCLE. States IDLE, RUN, DONE.
//  - IDLE: accept when i_in_valid && o_in_ready at edge E0; latch |dividend|, |divisor|, sign flags, counter=N.
//      divisor==0            -> DONE at E0 (no RUN): q=all-ones, r=dividend (both modes).
//      signed && dividend==MIN && divisor==-1 -> DONE at E0: q=MIN (0x8000_0000), r=0.
//      else                  -> RUN.
//  - RUN: each edge performs BITS_PER_CYCLE chained steps: rem=(rem<<1)|msb(dvd); dvd<<=1;
//      if rem>=divisor {rem-=divisor; q=(q<<1)|1} else q<<=1. Counter decrements; at 0 -> DONE.
//      Normal latency: o_out_valid high exactly N cycles after E0 (32/4 -> 8). Special cases: 1 cycle.
//  - Sign fix (signed mode only): quotient negated iff operand signs differ; remainder takes dividend sign.
//      Applied when entering DONE; outputs are registered, never combinational from inputs.
//  - Magnitudes and remainder held at WIDTH bits; |MIN| = 2^(WIDTH-1) fits as unsigned WIDTH bits.
//  - DONE: o_out_valid=1, o_quotient/o_remainder stable until i_out_ready; then IDLE next edge.
//      No accept in DONE (o_in_ready=0): steady-state throughput 1 op per N+2 cycles.
//  - i_flush: any state -> IDLE next edge, o_out_valid drops, result lost; flush wins over accept and
//      over output handshake in the same cycle. Outputs keep last values (not cleared).
//  - rst mid-RUN/DONE: immediate return to reset values; in-flight op lost.
//  - Inputs sampled only at the accept edge; changes during RUN/DONE have no effect.
// STRUCTURE
//  - divider_pkg: typedef enum logic [1:0] {DIV_IDLE, DIV_RUN, DIV_DONE} div_state_e;
//    function for counter width $clog2(N+1).
//  - Sub-module divider_step (combinational, WIDTH-parametrised, one restoring step:
//    in dividend/remainder/quotient/divisor, out shifted dividend/remainder/quotient);
//    instantiated BITS_PER_CYCLE times in a generate chain feeding the RUN registers.
//  - One always_ff (async reset) for state/datapath regs; one always_comb for next-state.
// TESTING
//  - Unsigned 7/2 -> q=3, r=1, o_out_valid exactly 8 cycles after accept, o_in_ready=0 meanwhile.
//  - Signed -7/2 (0xFFFF_FFF9, 0x2) -> q=0xFFFF_FFFD, r=0xFFFF_FFFF; 7/-2 -> q=0xFFFF_FFFD, r=1.
//  - Divide by zero 0x1234/0, both modes -> q=0xFFFF_FFFF, r=0x1234, valid 1 cycle after accept.
//  - 0x8000_0000/0xFFFF_FFFF signed -> q=0x8000_0000, r=0 (1 cycle); unsigned -> q=0, r=0x8000_0000 (8 cycles).
//  - Backpressure: hold i_out_ready=0 for 5 cycles in DONE -> outputs stable, o_in_ready=0; release -> IDLE.
//  - i_flush at RUN cycle 3, then new op 100/7 -> no stale valid; q=14, r=2. Async rst mid-RUN -> reset values.
//  - Randomised sweep vs reference model for BITS_PER_CYCLE in {1,4,32}, WIDTH in {8,32}.

Source files
------------

// File: rtl/divider_pkg.sv
// divider_pkg: shared state type and sizing helper for the iterative divider
package divider_pkg;
  typedef enum logic [1:0] {DIV_IDLE, DIV_RUN, DIV_DONE} div_state_e;
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/divider_step.sv
// divider_step: one combinational restoring-division step on unsigned magnitudes
module divider_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] dvd_i,
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] dsr_i,
  output logic [WIDTH-1:0] dvd_o,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);
  logic [WIDTH:0] trial;
  logic [WIDTH:0] diff;
  logic           ge;
  // One extra bit: the shifted remainder can reach 2*divisor-1
  assign trial = {rem_i, dvd_i[WIDTH-1]};
  assign diff  = trial - {1'b0, dsr_i};
  assign ge    = trial >= {1'b0, dsr_i};
  assign dvd_o = {dvd_i[WIDTH-2:0], 1'b0};
  assign rem_o = ge ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
  assign quo_o = {quo_i[WIDTH-2:0], ge};
endmodule

// File: rtl/divider_iterative.sv
// divider_iterative: multi-cycle signed/unsigned divider retiring BITS_PER_CYCLE quotient bits per clock
module divider_iterative
  import divider_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_flush,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  input  logic             i_signed,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder
);
  localparam int N  = WIDTH / BITS_PER_CYCLE;
  localparam int CW = cnt_width(N);
  localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};
  if (WIDTH % BITS_PER_CYCLE != 0) begin : g_bad_bpc
    $error("BITS_PER_CYCLE must divide WIDTH");
  end
  div_state_e      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] dvd_q, dvd_d, rem_q, rem_d, quo_q, quo_d, dsr_q, dsr_d;
  logic [WIDTH-1:0] q_out_q, q_out_d, r_out_q, r_out_d;
  logic            neg_q_q, neg_q_d, neg_r_q, neg_r_d;
  logic [WIDTH-1:0] dvd_c [BITS_PER_CYCLE+1];
  logic [WIDTH-1:0] rem_c [BITS_PER_CYCLE+1];
  logic [WIDTH-1:0] quo_c [BITS_PER_CYCLE+1];
  logic [WIDTH-1:0] dvd_abs, dsr_abs;
  assign dvd_abs = (i_signed && i_dividend[WIDTH-1]) ? -i_dividend : i_dividend;
  assign dsr_abs = (i_signed && i_divisor[WIDTH-1]) ? -i_divisor : i_divisor;
  assign dvd_c[0] = dvd_q;
  assign rem_c[0] = rem_q;
  assign quo_c[0] = quo_q;
  for (genvar g = 0; g < BITS_PER_CYCLE; g++) begin : g_step
    divider_step #(.WIDTH(WIDTH)) u_step (
      .dvd_i(dvd_c[g]), .rem_i(rem_c[g]), .quo_i(quo_c[g]), .dsr_i(dsr_q),
      .dvd_o(dvd_c[g+1]), .rem_o(rem_c[g+1]), .quo_o(quo_c[g+1])
    );
  end
  assign o_in_ready  = state_q == DIV_IDLE;
  assign o_out_valid = state_q == DIV_DONE;
  assign o_quotient  = q_out_q;
  assign o_remainder = r_out_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dsr_d   = dsr_q;
    q_out_d = q_out_q;
    r_out_d = r_out_q;
    neg_q_d = neg_q_q;
    neg_r_d = neg_r_q;
    case (state_q)
      DIV_IDLE: if (i_in_valid) begin
        neg_q_d = i_signed && (i_dividend[WIDTH-1] ^ i_divisor[WIDTH-1]);
        neg_r_d = i_signed && i_dividend[WIDTH-1];
        dvd_d   = dvd_abs;
        dsr_d   = dsr_abs;
        rem_d   = '0;
        quo_d   = '0;
        cnt_d   = CW'(N);
        if (i_divisor == '0) begin
          state_d = DIV_DONE;
          q_out_d = '1;
          r_out_d = i_dividend;
        end else if (i_signed && i_dividend == MIN && i_divisor == '1) begin
          state_d = DIV_DONE;
          q_out_d = MIN;
          r_out_d = '0;
        end else begin
          state_d = DIV_RUN;
        end
      end
      DIV_RUN: begin
        dvd_d = dvd_c[BITS_PER_CYCLE];
        rem_d = rem_c[BITS_PER_CYCLE];
        quo_d = quo_c[BITS_PER_CYCLE];
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = DIV_DONE;
          q_out_d = neg_q_q ? -quo_c[BITS_PER_CYCLE] : quo_c[BITS_PER_CYCLE];
          r_out_d = neg_r_q ? -rem_c[BITS_PER_CYCLE] : rem_c[BITS_PER_CYCLE];
        end
      end
      DIV_DONE: state_d = i_out_ready ? DIV_IDLE : DIV_DONE;
      default:  state_d = DIV_IDLE;
    endcase
    // A flushed op must not leak into the visible result registers
    if (i_flush) begin
      state_d = DIV_IDLE;
      q_out_d = q_out_q;
      r_out_d = r_out_q;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dsr_q   <= '0;
      q_out_q <= '0;
      r_out_q <= '0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dsr_q   <= dsr_d;
      q_out_q <= q_out_d;
      r_out_q <= r_out_d;
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
    end
  end
endmodule
